// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if
//   Groups the control and status signals of the reset sequencer.
//   clk and rst stay outside the interface as plain scalar ports.
//
//   sw_rst_req : request, one-cycle pulse, sampled on posedge clk
//   ch_en      : per-channel enable, quasi-static
//   rst_out    : active-low channel resets, bit i = channel i
//   ready      : all enabled channels released
//   seq_cnt    : completed release sequences, saturating
//   dbg_state  : current sequencer FSM state, for checkers
//
//   Handshake: there is no valid/ready pair. sw_rst_req is a fire-and-forget
//   pulse; it takes effect only when seen while the sequencer is idle
//   (ready high, FSM in RUN) and is dropped, not queued, at any other time.
//   ready is a level, not an acknowledge.
interface reset_sequencer_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);
    logic             sw_rst_req;
    logic [N_CH-1:0]  ch_en;
    logic [N_CH-1:0]  rst_out;
    logic             ready;
    logic [CNT_W-1:0] seq_cnt;
    logic [1:0]       dbg_state;

    // master: whoever requests resets and watches status
    modport master (
        output sw_rst_req, ch_en,
        input  rst_out, ready, seq_cnt, dbg_state
    );

    // slave: the sequencer itself
    modport slave (
        input  sw_rst_req, ch_en,
        output rst_out, ready, seq_cnt, dbg_state
    );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Multi-channel reset generator. Every channel reset is asserted
//   asynchronously by rst and released synchronously: after a synchronizer
//   and a hold period, channels are released one by one, STAGGER cycles
//   apart. A software request in RUN re-runs the hold/release part.
//
//   clk  : system clock, posedge
//   rst  : asynchronous active-low reset
//   bus  : reset_sequencer_if slave (sw_rst_req, ch_en in;
//          rst_out, ready, seq_cnt, dbg_state out)
module reset_sequencer #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 3,
    parameter int STAGGER     = 2,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    reset_sequencer_if.slave  bus
);
    localparam int TMAX = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
    localparam int TW   = ($clog2(TMAX + 1) > 1) ? $clog2(TMAX + 1) : 1;
    localparam int IW   = (N_CH > 1) ? $clog2(N_CH) : 1;

    // Timer load values are "cycles minus one": the timer counts down to 0
    // and the action happens on the edge that sees 0.
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] STAG_LOAD = TW'((STAGGER > 0) ? STAGGER - 1 : 0);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N_CH - 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    state_t                 state;
    logic [TW-1:0]          tmr;
    logic [IW-1:0]          idx;
    logic [N_CH-1:0]        rst_out_q;
    logic                   ready_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   sync_rise;
    logic                   seq_done;

    // Deassertion synchronizer: shifts in ones once rst is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // The edge on which the synchronizer output goes high is the edge that
    // counts as "sync high"; leaving ASSERT on that edge lets the hold period
    // start counting on the very next edge.
    assign sync_rise = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];

    // Last release slot of the sequence is being taken on this edge.
    assign seq_done = ((state == ST_HOLD) && (tmr == '0) && ((STAGGER == 0) || (N_CH == 1)))
                   || ((state == ST_RELEASE) && (tmr == '0) && (idx == LAST_IDX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_ASSERT;
            tmr       <= '0;
            idx       <= '0;
            rst_out_q <= '0;
            ready_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state)
                ST_ASSERT: begin
                    if (sync_rise) begin
                        state <= ST_HOLD;
                        tmr   <= HOLD_LOAD;
                    end
                end
                ST_HOLD: begin
                    if (tmr != '0) begin
                        tmr <= tmr - TW'(1);
                    end else if (STAGGER == 0) begin
                        rst_out_q <= bus.ch_en;
                    end else begin
                        // Slot 0; a disabled channel simply keeps its 0.
                        rst_out_q[0] <= bus.ch_en[0];
                        if (N_CH > 1) begin
                            state <= ST_RELEASE;
                            idx   <= IW'(1);
                            tmr   <= STAG_LOAD;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (tmr != '0) begin
                        tmr <= tmr - TW'(1);
                    end else begin
                        rst_out_q[idx] <= bus.ch_en[idx];
                        if (idx != LAST_IDX) begin
                            idx <= idx + IW'(1);
                            tmr <= STAG_LOAD;
                        end
                    end
                end
                ST_RUN: begin
                    // Software reset skips the synchronizer: clk is known good.
                    if (bus.sw_rst_req) begin
                        rst_out_q <= '0;
                        ready_q   <= 1'b0;
                        state     <= ST_HOLD;
                        tmr       <= HOLD_LOAD;
                    end
                end
                default: state <= ST_ASSERT;
            endcase

            if (seq_done) begin
                state   <= ST_RUN;
                ready_q <= 1'b1;
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign bus.rst_out   = rst_out_q;
    assign bus.ready     = ready_q;
    assign bus.seq_cnt   = cnt_q;
    assign bus.dbg_state = state;
endmodule
